// File: rtl/alu_byte_seq_if.sv
// Bundle of the control-unit request/response signals and the byte-wide ALU bus.
// master = control unit plus ALU side, slave = the byte sequencer.
interface alu_byte_seq_if #(
  parameter int NBYTES = 2
);
  logic                  start;
  logic [1:0]            op;
  logic                  cin;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [8*NBYTES-1:0]   result;
  logic                  cout;
  logic                  zero;
  logic                  parity;
  logic [3:0]            alu_cmd;
  logic [7:0]            alu_inA;
  logic [7:0]            alu_inB;
  logic                  alu_sc_i;
  logic [7:0]            alu_rslt;
  logic                  alu_sc_o;

  modport master (
    output start, op, cin, a, b, alu_rslt, alu_sc_o,
    input  busy, done, result, cout, zero, parity,
    input  alu_cmd, alu_inA, alu_inB, alu_sc_i
  );

  modport slave (
    input  start, op, cin, a, b, alu_rslt, alu_sc_o,
    output busy, done, result, cout, zero, parity,
    output alu_cmd, alu_inA, alu_inB, alu_sc_i
  );
endinterface

// File: rtl/alu_byte_seq.sv
// Steps an 8-bit ALU across NBYTES operand bytes, LSB first, chaining the
// carry through a register and reporting the wide result with flags.
module alu_byte_seq #(
  parameter int NBYTES = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_byte_seq_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic [NBYTES-1:0] byte_hit;
  logic [7:0]      byte_a, byte_b;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_hit
    assign byte_hit[gi] = (idx_q == IW'(gi));
  end

  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_hit[i]) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    cout_d       = cout_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    bus.alu_cmd  = 4'b0000;
    bus.alu_inA  = '0;
    bus.alu_inB  = '0;
    bus.alu_sc_i = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_d     = bus.op;
          idx_d    = '0;
          carry_d  = (bus.op == OP_ADD) & bus.cin;
          result_d = '0;
          cout_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        case (op_q)
          OP_ADD:  bus.alu_cmd = 4'b0000;
          OP_MOV:  bus.alu_cmd = 4'b0010;
          OP_XOR:  bus.alu_cmd = 4'b0100;
          default: bus.alu_cmd = 4'b1110;
        endcase
        bus.alu_inA  = byte_a;
        bus.alu_inB  = byte_b;
        bus.alu_sc_i = carry_q;
        for (int i = 0; i < NBYTES; i++) begin
          if (byte_hit[i]) result_d[8*i +: 8] = bus.alu_rslt;
        end
        carry_d = (op_q == OP_ADD) & bus.alu_sc_o;
        idx_d   = idx_q + 1'b1;
        // Termination is by compare on the last byte, never by index overflow.
        if (idx_q == LAST_IDX) begin
          cout_d  = carry_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = ~|result_q;
  assign bus.parity = ^result_q;
endmodule

// File: tb/tb_alu_byte_seq.sv
// Bench for alu_byte_seq: behavioural ALU byte model plus a wide-arithmetic
// reference, exercising 2-byte and 4-byte instances.
module tb_alu_byte_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_byte_seq_if #(.NBYTES(2)) bus2();
  alu_byte_seq_if #(.NBYTES(4)) bus4();

  alu_byte_seq #(.NBYTES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  alu_byte_seq #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  // Byte-wide ALU: {carry_out, result}
  function automatic logic [8:0] alu_model(input logic [3:0] cmd, input logic [7:0] x,
                                           input logic [7:0] y, input logic c);
    case (cmd)
      4'b0000: return {1'b0, x} + {1'b0, y} + {8'd0, c};
      4'b0010: return {1'b0, y};
      4'b0100: return {1'b0, x ^ y};
      4'b1110: return {1'b0, x & y};
      default: return 9'd0;
    endcase
  endfunction

  assign {bus2.alu_sc_o, bus2.alu_rslt} = alu_model(bus2.alu_cmd, bus2.alu_inA, bus2.alu_inB, bus2.alu_sc_i);
  assign {bus4.alu_sc_o, bus4.alu_rslt} = alu_model(bus4.alu_cmd, bus4.alu_inA, bus4.alu_inB, bus4.alu_sc_i);

  // Wide reference: bits [8*nb-1:0] result, bit 8*nb carry out
  function automatic logic [32:0] ref_wide(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin, input int nb);
    logic [32:0] mask;
    mask = (33'd1 << (8 * nb)) - 33'd1;
    case (op)
      2'b00:   return ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, cin};
      2'b01:   return {1'b0, b} & mask;
      2'b10:   return {1'b0, a ^ b} & mask;
      default: return {1'b0, a & b} & mask;
    endcase
  endfunction

  task automatic launch2(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus2.start = 1'b1; bus2.op = op; bus2.a = a; bus2.b = b; bus2.cin = cin;
    @(posedge clk);
    @(negedge clk);
    bus2.start = 1'b0;
    bus2.a = 16'($urandom); bus2.b = 16'($urandom);
    bus2.op = 2'($urandom); bus2.cin = 1'($urandom);
  endtask

  task automatic wait_done2(output int cyc);
    cyc = 0;
    while (bus2.done !== 1'b1 && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus2.busy, bus2.done, bus2.result, bus2.cout, bus2.zero, bus2.parity} !== {2'b00, 16'h0000, 3'b010}) begin
      n_err++;
      $display("FAIL reset2 got busy/done/res/cout/zero/par=%b/%b/%h/%b/%b/%b want 0/0/0000/0/1/0",
               bus2.busy, bus2.done, bus2.result, bus2.cout, bus2.zero, bus2.parity);
    end
    n_cmp++;
    if ({bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.zero, bus4.parity} !== {2'b00, 32'h0, 3'b010}) begin
      n_err++;
      $display("FAIL reset4 got busy/done/res/cout/zero/par=%b/%b/%h/%b/%b/%b want 0/0/0/0/1/0",
               bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.zero, bus4.parity);
    end
    n_cmp++;
    if ({bus2.alu_cmd, bus2.alu_inA, bus2.alu_inB, bus2.alu_sc_i} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_alu_bus got cmd=%h A=%h B=%h sc=%b want all 0",
               bus2.alu_cmd, bus2.alu_inA, bus2.alu_inB, bus2.alu_sc_i);
    end
    $display("reset checked");
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        co;
    logic        z;
    logic        p;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[6];
    int   cyc;
    vecs[0] = '{2'd0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2'd0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'd2, 16'hA5A5, 16'hFFFF, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 16'h1234, 16'h00FF, 1'b1, 16'h0034, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{2'd1, 16'h1111, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      launch2(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      n_cmp++;
      if (bus2.busy !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_busy got %b want 1", i, bus2.busy);
      end
      wait_done2(cyc);
      n_cmp++;
      if (cyc !== 2) begin
        n_err++;
        $display("FAIL dir%0d_latency got %0d want 2 cycles after accept", i, cyc);
      end
      n_cmp++;
      if ({bus2.result, bus2.cout, bus2.zero, bus2.parity, bus2.busy} !==
          {vecs[i].res, vecs[i].co, vecs[i].z, vecs[i].p, 1'b0}) begin
        n_err++;
        $display("FAIL dir%0d_out got res=%h c=%b z=%b p=%b busy=%b want res=%h c=%b z=%b p=%b busy=0",
                 i, bus2.result, bus2.cout, bus2.zero, bus2.parity, bus2.busy,
                 vecs[i].res, vecs[i].co, vecs[i].z, vecs[i].p);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus2.done, bus2.busy, bus2.alu_cmd, bus2.alu_inA, bus2.alu_inB, bus2.alu_sc_i, bus2.result} !==
          {23'd0, vecs[i].res}) begin
        n_err++;
        $display("FAIL dir%0d_idle got done=%b busy=%b cmd=%h A=%h B=%h sc=%b res=%h want 0s, res=%h",
                 i, bus2.done, bus2.busy, bus2.alu_cmd, bus2.alu_inA, bus2.alu_inB, bus2.alu_sc_i,
                 bus2.result, vecs[i].res);
      end
      $display("directed op=%0d a=%h b=%h cin=%b -> res=%h cout=%b", vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].cin, bus2.result, bus2.cout);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] a, b, er;
    logic        cin, ec;
    logic [32:0] r;
    int          cyc;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      if (i % 5 == 0) b = 16'hFFFF - a;
      r  = ref_wide(op, {16'd0, a}, {16'd0, b}, cin, 2);
      er = r[15:0];
      ec = r[16];
      launch2(op, a, b, cin);
      wait_done2(cyc);
      n_cmp++;
      if (cyc !== 2) begin
        n_err++;
        $display("FAIL rnd%0d_latency got %0d want 2", i, cyc);
      end
      n_cmp++;
      if ({bus2.result, bus2.cout, bus2.zero, bus2.parity} !== {er, ec, (er == 16'd0), ^er}) begin
        n_err++;
        $display("FAIL rnd%0d op=%0d a=%h b=%h cin=%b got res=%h c=%b z=%b p=%b want res=%h c=%b z=%b p=%b",
                 i, op, a, b, cin, bus2.result, bus2.cout, bus2.zero, bus2.parity,
                 er, ec, (er == 16'd0), ^er);
      end
      $display("random op=%0d a=%h b=%h cin=%b -> res=%h cout=%b", op, a, b, cin, bus2.result, bus2.cout);
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    int          dones;
    logic [15:0] seen;
    dones = 0;
    seen  = 16'hDEAD;
    launch2(2'd0, 16'h0101, 16'h0101, 1'b0);
    bus2.start = 1'b1; bus2.op = 2'd2; bus2.a = 16'hFFFF; bus2.b = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus2.start = 1'b0;
      if (bus2.done === 1'b1) begin
        dones++;
        seen = bus2.result;
      end
    end
    n_cmp++;
    if (dones !== 1) begin
      n_err++;
      $display("FAIL ignore_start_dones got %0d want 1", dones);
    end
    n_cmp++;
    if (seen !== 16'h0202) begin
      n_err++;
      $display("FAIL ignore_start_result got %h want 0202", seen);
    end
    $display("ignore_start: dones=%0d res=%h", dones, seen);
  endtask

  task automatic test_reset_midrun();
    int dones;
    int cyc;
    dones = 0;
    launch2(2'd0, 16'h1234, 16'h5678, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus2.busy, bus2.done, bus2.result, bus2.cout, bus2.zero, bus2.parity, bus2.alu_cmd, bus2.alu_inA} !==
        {2'b00, 16'h0000, 3'b010, 12'd0}) begin
      n_err++;
      $display("FAIL midrun_reset got busy=%b done=%b res=%h c=%b z=%b p=%b cmd=%h A=%h want 0/0/0000/0/1/0/0/00",
               bus2.busy, bus2.done, bus2.result, bus2.cout, bus2.zero, bus2.parity, bus2.alu_cmd, bus2.alu_inA);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus2.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL midrun_no_done got %0d pulses want 0", dones);
    end
    launch2(2'd0, 16'h0002, 16'h0003, 1'b0);
    wait_done2(cyc);
    n_cmp++;
    if ({bus2.result, bus2.cout} !== {16'h0005, 1'b0} || cyc !== 2) begin
      n_err++;
      $display("FAIL midrun_after got res=%h c=%b lat=%0d want 0005/0/2", bus2.result, bus2.cout, cyc);
    end
    $display("reset_midrun: post-reset add res=%h", bus2.result);
    @(negedge clk);
  endtask

  task automatic test_nbytes4();
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [32:0] r;
    int          cyc;
    bus4.start = 1'b1; bus4.op = 2'd0; bus4.a = 32'hFFFF_FFFF; bus4.b = 32'h0000_0001; bus4.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus4.start = 1'b0; bus4.a = 32'h0; bus4.b = 32'h0;
    n_cmp++;
    if ({bus4.busy, bus4.alu_sc_i} !== 2'b10) begin
      n_err++;
      $display("FAIL n4_byte0 got busy=%b sc_i=%b want 1/0", bus4.busy, bus4.alu_sc_i);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus4.busy, bus4.alu_sc_i} !== 2'b11) begin
        n_err++;
        $display("FAIL n4_byte%0d got busy=%b sc_i=%b want 1/1", k, bus4.busy, bus4.alu_sc_i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus4.done, bus4.result, bus4.cout, bus4.zero} !== {1'b1, 32'h0, 2'b11}) begin
      n_err++;
      $display("FAIL n4_add got done=%b res=%h c=%b z=%b want 1/00000000/1/1",
               bus4.done, bus4.result, bus4.cout, bus4.zero);
    end
    $display("nbytes4 add FFFFFFFF+1 -> res=%h cout=%b", bus4.result, bus4.cout);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
      r = ref_wide(op, a, b, cin, 4);
      bus4.start = 1'b1; bus4.op = op; bus4.a = a; bus4.b = b; bus4.cin = cin;
      @(posedge clk);
      @(negedge clk);
      bus4.start = 1'b0; bus4.a = $urandom; bus4.b = $urandom;
      cyc = 0;
      while (bus4.done !== 1'b1 && cyc < 16) begin
        @(negedge clk);
        cyc++;
      end
      n_cmp++;
      if ({bus4.result, bus4.cout, bus4.parity} !== {r[31:0], r[32], ^r[31:0]} || cyc !== 4) begin
        n_err++;
        $display("FAIL n4_rnd%0d op=%0d got res=%h c=%b p=%b lat=%0d want res=%h c=%b p=%b lat=4",
                 i, op, bus4.result, bus4.cout, bus4.parity, cyc, r[31:0], r[32], ^r[31:0]);
      end
      $display("nbytes4 op=%0d a=%h b=%h cin=%b -> res=%h cout=%b", op, a, b, cin, bus4.result, bus4.cout);
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int dones;
    int bad;
    dones = 0;
    bad   = 0;
    bus2.start = 1'b1; bus2.op = 2'd0; bus2.a = 16'h1111; bus2.b = 16'h2222; bus2.cin = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus2.done === 1'b1) begin
        dones++;
        if (bus2.result !== 16'h3333) bad++;
      end
    end
    bus2.start = 1'b0;
    n_cmp++;
    if (dones !== 4 || bad !== 0) begin
      n_err++;
      $display("FAIL back_to_back got %0d dones (%0d wrong results) want 4 dones of 3333", dones, bad);
    end
    $display("back_to_back: %0d operations completed", dones);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus2.start = 1'b0; bus2.op = 2'd0; bus2.cin = 1'b0; bus2.a = '0; bus2.b = '0;
    bus4.start = 1'b0; bus4.op = 2'd0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_midrun();
    test_nbytes4();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
